// File: rtl/ntt_pkg.sv
// ntt_pkg: shared defaults, mode encodings, the Barrett constant and the
// modular add/sub helpers used by the NTT butterfly pipeline.
package ntt_pkg;

    localparam int WIDTH_DEFAULT = 18;
    localparam int Q_DEFAULT     = 12289;

    localparam logic MODE_CT = 1'b0;
    localparam logic MODE_GS = 1'b1;

    // Operand width of the add/sub helpers; callers zero-extend into it.
    localparam int OPW = 32;

    // Barrett constant floor(2^(2k)/q) with k = clog2(q).
    function automatic logic [63:0] barrett_m(input int unsigned q);
        logic [63:0] num;
        num = 64'd1 << (2 * $clog2(q));
        return num / 64'(q);
    endfunction

    // (a + b) mod q for a, b in [0, q-1]; one extra bit holds the raw sum.
    function automatic logic [OPW-1:0] mod_add(input logic [OPW-1:0] a,
                                               input logic [OPW-1:0] b,
                                               input logic [OPW-1:0] q);
        logic [OPW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, q}) begin
            s = s - {1'b0, q};
        end else begin
            s = s;
        end
        return OPW'(s);
    endfunction

    // (a - b) mod q for a, b in [0, q-1]; adding q first keeps it non-negative.
    function automatic logic [OPW-1:0] mod_sub(input logic [OPW-1:0] a,
                                               input logic [OPW-1:0] b,
                                               input logic [OPW-1:0] q);
        logic [OPW-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = a + q - b;
        end
        return d;
    endfunction

endpackage

// File: rtl/ntt_butterfly_pipe_if.sv
// ntt_butterfly_pipe_if: input beat and result beat handshake bundles of the
// butterfly unit. master = producer/consumer side, slave = the butterfly.
interface ntt_butterfly_pipe_if #(
    parameter int WIDTH = ntt_pkg::WIDTH_DEFAULT
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_w;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;

    modport master (
        output in_valid, in_mode, in_a, in_b, in_w, out_ready,
        input  in_ready, out_valid, out_a, out_b
    );

    modport slave (
        input  in_valid, in_mode, in_a, in_b, in_w, out_ready,
        output in_ready, out_valid, out_a, out_b
    );
endinterface

// File: rtl/mod_mul_reduce.sv
// mod_mul_reduce: one registered Barrett reduction stage, 2*WIDTH -> WIDTH,
// exact for every input below Q^2.
module mod_mul_reduce #(
    parameter int WIDTH = ntt_pkg::WIDTH_DEFAULT,
    parameter int Q     = ntt_pkg::Q_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en_i,
    input  logic [2*WIDTH-1:0] x_i,
    output logic [WIDTH-1:0]   r_o
);
    import ntt_pkg::*;

    localparam int              K    = $clog2(Q);
    localparam int              XW   = 2 * WIDTH;
    localparam int              PW   = 3 * WIDTH + 1;
    localparam logic [63:0]     BM   = barrett_m(Q);
    localparam logic [PW-1:0]   BM_P = PW'(BM);
    localparam logic [PW-1:0]   Q_P  = PW'(Q);
    localparam logic [XW-1:0]   Q_X  = XW'(Q);

    logic [XW-1:0]    rem0_s;
    logic [XW-1:0]    rem1_s;
    logic [XW-1:0]    rem2_s;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] r_q;

    // Quotient estimate is at most two short, so two conditional subtracts finish the job.
    always_comb begin
        rem0_s = x_i - XW'(((PW'(x_i) * BM_P) >> (2 * K)) * Q_P);
        if (rem0_s >= Q_X) begin
            rem1_s = rem0_s - Q_X;
        end else begin
            rem1_s = rem0_s;
        end
        if (rem1_s >= Q_X) begin
            rem2_s = rem1_s - Q_X;
        end else begin
            rem2_s = rem1_s;
        end
        r_d = WIDTH'(rem2_s);
    end

    // Result register, held while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= r_d;
        end
    end

    assign r_o = r_q;

endmodule

// File: rtl/ntt_butterfly_pipe.sv
// ntt_butterfly_pipe: four-stage Cooley-Tukey / Gentleman-Sande NTT butterfly
// with twiddle multiply, Barrett reduction and whole-pipeline stall.
// Build option: NTT_BFLY_RANGE_CHECK_EN adds the sticky err output.
// GS beats have their sum/difference formed in front of the first register, so
// both modes use the single multiplier (stage 2) and single reducer (stage 3)
// at the same depth and mixed-mode streams never collide on them.
module ntt_butterfly_pipe #(
    parameter int WIDTH = ntt_pkg::WIDTH_DEFAULT,
    parameter int Q     = ntt_pkg::Q_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    ntt_butterfly_pipe_if.slave bus
`ifdef NTT_BFLY_RANGE_CHECK_EN
    ,
    output logic err
`endif
);
    import ntt_pkg::*;

    localparam int PW = 2 * WIDTH;

    logic             advance_s;
    logic             accept_s;
    logic [WIDTH-1:0] a1_d;
    logic [WIDTH-1:0] b1_d;
    logic             v1_q, m1_q, v2_q, m2_q, v3_q, m3_q, v4_q;
    logic [WIDTH-1:0] a1_q, b1_q, w1_q, a2_q, a3_q, r3_q;
    logic [PW-1:0]    p2_d;
    logic [PW-1:0]    p2_q;
    logic [WIDTH-1:0] out_a_d, out_b_d, out_a_q, out_b_q;

    assign advance_s     = !v4_q || bus.out_ready;
    assign accept_s      = bus.in_valid && advance_s;
    assign bus.in_ready  = advance_s;
    assign bus.out_valid = v4_q;
    assign bus.out_a     = out_a_q;
    assign bus.out_b     = out_b_q;

    // Stage-1 operand select: GS beats enter as (a+b, a-b) so stage 2 multiplies b-side by w.
    always_comb begin
        a1_d = bus.in_a;
        b1_d = bus.in_b;
        if (bus.in_mode == MODE_GS) begin
            a1_d = WIDTH'(mod_add(OPW'(bus.in_a), OPW'(bus.in_b), OPW'(Q)));
            b1_d = WIDTH'(mod_sub(OPW'(bus.in_a), OPW'(bus.in_b), OPW'(Q)));
        end else begin
            a1_d = bus.in_a;
            b1_d = bus.in_b;
        end
    end

    assign p2_d = PW'(b1_q) * PW'(w1_q);

    // Stage-4 combine: CT adds/subtracts the reduced product, GS passes sum and product through.
    always_comb begin
        out_a_d = a3_q;
        out_b_d = r3_q;
        if (m3_q == MODE_GS) begin
            out_a_d = a3_q;
            out_b_d = r3_q;
        end else begin
            out_a_d = WIDTH'(mod_add(OPW'(a3_q), OPW'(r3_q), OPW'(Q)));
            out_b_d = WIDTH'(mod_sub(OPW'(a3_q), OPW'(r3_q), OPW'(Q)));
        end
    end

    // Pipeline registers: every stage advances together or holds together; reset drops all beats.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            m1_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            w1_q    <= '0;
            v2_q    <= 1'b0;
            m2_q    <= 1'b0;
            a2_q    <= '0;
            p2_q    <= '0;
            v3_q    <= 1'b0;
            m3_q    <= 1'b0;
            a3_q    <= '0;
            v4_q    <= 1'b0;
            out_a_q <= '0;
            out_b_q <= '0;
        end else if (advance_s) begin
            v1_q    <= accept_s;
            m1_q    <= bus.in_mode;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            w1_q    <= bus.in_w;
            v2_q    <= v1_q;
            m2_q    <= m1_q;
            a2_q    <= a1_q;
            p2_q    <= p2_d;
            v3_q    <= v2_q;
            m3_q    <= m2_q;
            a3_q    <= a2_q;
            v4_q    <= v3_q;
            out_a_q <= out_a_d;
            out_b_q <= out_b_d;
        end
    end

    mod_mul_reduce #(
        .WIDTH (WIDTH),
        .Q     (Q)
    ) u_reduce (
        .clk  (clk),
        .rst  (rst),
        .en_i (advance_s),
        .x_i  (p2_q),
        .r_o  (r3_q)
    );

`ifdef NTT_BFLY_RANGE_CHECK_EN
    localparam logic [WIDTH-1:0] QW = WIDTH'(Q);

    logic err_q;

    // Sticky range flag: any accepted operand at or above Q latches until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (accept_s && ((bus.in_a >= QW) || (bus.in_b >= QW) || (bus.in_w >= QW))) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`endif

endmodule

// File: tb/tb_ntt_butterfly_pipe.sv
// tb_ntt_butterfly_pipe: scoreboard bench for the NTT butterfly pipeline.
// Stimulus pushes expected results at acceptance; a negedge monitor pops and
// compares on every output transfer.
module tb_ntt_butterfly_pipe;
    localparam int WIDTH = 18;
    localparam int Q     = 12289;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             dc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ntt_butterfly_pipe_if #(.WIDTH(WIDTH)) bus ();
`ifdef NTT_BFLY_RANGE_CHECK_EN
    logic err;
`endif

    ntt_butterfly_pipe #(.WIDTH(WIDTH), .Q(Q)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef NTT_BFLY_RANGE_CHECK_EN
        ,
        .err (err)
`endif
    );

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t pend;
    int   cyc = 0;
    int   pop_total = 0;
    int   mark_at = -1;
    int   mark_cyc = 0;
    int   last_pop_cyc = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Reference butterfly computed directly with integer arithmetic.
    function automatic void model(input logic m, input longint unsigned a, b, w,
                                  output longint unsigned ea, eb);
        longint unsigned p;
        longint unsigned d;
        if (m == 1'b0) begin
            p  = (w * b) % Q;
            ea = (a + p) % Q;
            eb = (a + Q - p) % Q;
        end else begin
            ea = (a + b) % Q;
            d  = (a + Q - b) % Q;
            eb = (d * w) % Q;
        end
    endfunction

    // Monitor: scoreboard push on input transfer, pop and compare on output transfer.
    always @(negedge clk) begin : mon
        exp_t e;
        cyc++;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (bus.in_valid && bus.in_ready) exp_q.push_back(pend);
            if (bus.out_valid && bus.out_ready) begin
                if (pop_total == mark_at) mark_cyc = cyc;
                last_pop_cyc = cyc;
                pop_total++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_out: got beat a=%0d b=%0d, required no beat", bus.out_a, bus.out_b);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.dc) begin
                        check("out_a", bus.out_a, e.a);
                        check("out_b", bus.out_b, e.b);
                    end
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the beat's acceptance edge.
    task automatic send(input logic m, input longint unsigned a, b, w, ea, eb, input logic dc);
        int n;
        bus.in_valid = 1'b1;
        bus.in_mode  = m;
        bus.in_a     = 18'(a);
        bus.in_b     = 18'(b);
        bus.in_w     = 18'(w);
        pend.a       = 18'(ea);
        pend.b       = 18'(eb);
        pend.dc      = dc;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("accept", bus.in_ready, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic send_m(input logic m, input longint unsigned a, b, w);
        longint unsigned ea, eb;
        model(m, a, b, w, ea, eb);
        send(m, a, b, w, ea, eb, 1'b0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int p0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_w      = '0;
        bus.out_ready = 1'b1;
        pend          = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_a", bus.out_a, 0);
        check("rst_out_b", bus.out_b, 0);
`ifdef NTT_BFLY_RANGE_CHECK_EN
        check("rst_err", err, 0);
`endif
        @(posedge clk);
        #1;

        // Latency: CT 5,3,2 appears on the 4th cycle after acceptance.
        send(1'b0, 5, 3, 2, 11, 12288, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("latency_out_valid", bus.out_valid, (i == 3));
        end
        @(posedge clk);
        #1;

        // Directed vectors, back to back, hand-computed results.
        send(1'b1, 5,     3,     2,     8,     4,     1'b0);
        send(1'b0, 12288, 1,     1,     0,     12287, 1'b0);
        send(1'b1, 1,     12288, 3,     0,     6,     1'b0);
        send(1'b0, 0,     12288, 12288, 1,     12288, 1'b0);
        send(1'b1, 12288, 12288, 12288, 12287, 0,     1'b0);
        send(1'b0, 100,   7,     3000,  8811,  3678,  1'b0);
        send(1'b1, 7,     100,   5,     107,   11824, 1'b0);
        send(1'b0, 0,     0,     0,     0,     0,     1'b0);
        drain();

        // Streaming with alternating modes: one result per cycle after fill.
        mark_at = pop_total;
        for (int i = 0; i < 1000; i++) begin
            send_m(1'(i % 2), $urandom_range(Q - 1), $urandom_range(Q - 1), $urandom_range(Q - 1));
        end
        drain();
        check("stream_span", last_pop_cyc - mark_cyc, 999);

        // Stall for 3 cycles with 4 beats in flight.
        p0 = pop_total;
        send_m(1'b0, 1234, 5678, 9012);
        send_m(1'b1, 4321, 8765, 2109);
        send_m(1'b0, 11111, 2222, 3333);
        send_m(1'b1, 12000, 12100, 12200);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_in_ready", bus.in_ready, 0);
            check("stall_out_valid", bus.out_valid, 1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        drain();
        check("stall_pop_count", pop_total - p0, 4);

        // Reset while full and stalled: nothing stale may emerge.
        p0 = pop_total;
        send_m(1'b1, 10, 20, 30);
        send_m(1'b0, 40, 50, 60);
        send_m(1'b1, 70, 80, 90);
        send_m(1'b0, 11, 22, 33);
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_out_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_out_valid", bus.out_valid, 0);
        check("post_rst_in_ready", bus.in_ready, 1);
        check("post_rst_out_a", bus.out_a, 0);
        check("post_rst_out_b", bus.out_b, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        repeat (10) @(negedge clk);
        check("no_stale_beat", pop_total - p0, 0);
        @(posedge clk);
        #1;

`ifdef NTT_BFLY_RANGE_CHECK_EN
        // Out-of-range operand sets a sticky err, cleared only by reset.
        check("err_clear", err, 0);
        send(1'b0, 12289, 1, 1, 0, 0, 1'b1);
        @(negedge clk);
        check("err_set", err, 1);
        @(posedge clk);
        #1;
        send(1'b0, 5, 3, 2, 11, 12288, 1'b0);
        send(1'b1, 5, 3, 2, 8, 4, 1'b0);
        drain();
        check("err_sticky", err, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("err_after_rst", err, 0);
        @(posedge clk);
        #1;
`endif

        // Post-reset sanity beat.
        send(1'b0, 5, 3, 2, 11, 12288, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Time limit so the run always terminates.
    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, required end of test");
        $fatal(1, "time limit");
    end

endmodule
